instr_encoder_32: RTL and testbench
===================================

INSTR_ENCODER_32 -- requirements
Module: instr_encoder_32

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the instruction-memory word address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address after reset or restart.
REQ-003 SHALL have `clk`, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have `reset`, input, 1: synchronous, active-high reset.
REQ-005 SHALL have `restart`, input, 1: reload the address counter and clear the sticky flags.
REQ-006 SHALL have `in_valid` (input, 1) and `in_ready` (output, 1): the field-side handshake.
REQ-007 SHALL have `fmt`, input, 2: 0=R, 1=I, 2=J, 3=illegal.
REQ-008 SHALL have these field inputs: `opcode` 6, `rs` 5, `rt` 5, `rd` 5, `shamt` 5, `alu_function` 6, `immediate` 16, `jump_target` 26.
REQ-009 SHALL have `out_valid` (output, 1) and `out_ready` (input, 1): the word-side handshake.
REQ-010 SHALL have `instruction`, output, 32: the encoded word.
REQ-011 SHALL have `address`, output, ADDR_W: the word address paired with `instruction`.
REQ-012 SHALL have `err_illegal`, output, 1: sticky, set when an illegal fmt is consumed.
REQ-013 SHALL have `addr_wrap`, output, 1: sticky, set when the address counter wraps.

Function
REQ-014 SHALL define transfers: in transfer = `in_valid` & `in_ready`; out transfer = `out_valid` & `out_ready`.
REQ-015 SHALL encode an R-type word as {opcode, rs, rt, rd, shamt, alu_function}.
REQ-016 SHALL encode an I-type word as {opcode, rs, rt, immediate}; unused fields are ignored.
REQ-017 SHALL encode a J-type word as {opcode, jump_target}; unused fields are ignored.
REQ-018 SHALL buffer words in a 2-entry FIFO with occupancy state EMPTY, ONE or FULL.
REQ-019 SHALL drive `in_ready` = (state != FULL), derived from registered state only.
REQ-020 SHALL drive `out_valid` = (state != EMPTY).
REQ-021 SHALL present the oldest entry on `instruction` and `address`.
REQ-022 SHALL make a word accepted at edge N visible on `out_valid` after edge N: 1-cycle latency.
REQ-023 SHALL apply these occupancy transitions:
- push only: EMPTY→ONE, ONE→FULL.
- pop only: FULL→ONE, ONE→EMPTY.
- push+pop in ONE: stays ONE, and the new word becomes head on the next cycle.
- push+pop in FULL: cannot occur, because in_ready=0.
REQ-024 SHALL sustain one word per cycle with `out_ready` held high.
REQ-025 SHALL hold `instruction` and `address` stable while out_valid=1 and out_ready=0.
REQ-026 SHALL tag each valid word with the current counter value, then increment the counter modulo 2^ADDR_W.
REQ-027 SHALL set `addr_wrap` when the counter steps from all-ones to zero.
REQ-028 SHALL handle fmt=3 as follows:
- the word is consumed (in_ready unchanged).
- nothing is pushed.
- the counter is not incremented.
- `err_illegal` is set.
REQ-029 SHALL, on `restart`:
- load the counter with BASE_ADDR.
- clear `err_illegal` and `addr_wrap`.
- leave FIFO contents intact.
REQ-030 SHALL, on `restart` with a simultaneous valid transfer, tag that word with BASE_ADDR and load the counter with BASE_ADDR+1.
REQ-031 SHALL, on `restart` with a simultaneous illegal transfer, leave `err_illegal` set, because the error takes priority over the clear.

Reset
REQ-032 SHALL, while `reset`=1 at a rising edge:
- state → EMPTY, counter → BASE_ADDR.
- both flags → 0.
- `instruction` → 0, `address` → BASE_ADDR, out_valid → 0, in_ready → 1 on the next cycle.
REQ-033 SHALL discard any buffered words on a reset mid-stream, and SHALL ignore in_valid during the reset cycle.
REQ-034 SHALL give `reset` priority over `restart` and over both handshakes.

Structure
REQ-035 SHALL place these items in shared package mips_pkg, which is reused by decoder_32 users:
- the fmt encoding constants (FMT_R, FMT_I, FMT_J).
- the field widths and bit positions.
- the FIFO state type.
REQ-036 SHALL put the pure field-packing logic in one combinational sub-module, instr_pack_32, instantiated once ahead of the FIFO.

Verification
REQ-037 SHALL cover an R-type word: fmt=0, opcode=0, rs=1, rt=2, rd=3, shamt=0, alu_function=0x20 → instruction=0x00221820, address=0.
REQ-038 SHALL cover I-type then J-type back to back, with out_ready=1:
- input 1: fmt=1, opcode=0x08, rs=1, rt=2, immediate=0xFFFF → 0x2022FFFF at address 0.
- input 2: fmt=2, opcode=2, jump_target=0x3FFFFFF → 0x0BFFFFFF at address 1, on consecutive cycles.
REQ-039 SHALL cover backpressure: out_ready=0 with 3 words offered → in_ready=0 after 2 accepts, and the first word stays stable; release → words 0,1,2 emerge in order with addresses 0,1,2.
REQ-040 SHALL cover an illegal format: fmt=3 between two R words → err_illegal=1, the output words get addresses 0 and 1, and nothing is emitted for the illegal word.
REQ-041 SHALL cover wrap: ADDR_W=2 with 5 words → addresses 0,1,2,3,0, and addr_wrap=1 after the 4th word.
REQ-042 SHALL cover restart and reset:
- restart together with a word (BASE_ADDR=4) → that word's address=4, the next word's address=5, flags cleared.
- reset with FULL state → out_valid=0 the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS field layout, format codes and FIFO occupancy type.
// Used by both the instruction encoder and decoder_32.
package mips_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/instr_pack_32.sv
// Pure field packing of R/I/J words; flags fmt=3 as not legal.
// Fields unused by the selected format never reach the word.
module instr_pack_32
  import mips_pkg::*;
(
  input  logic [1:0]          fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [FUNCT_W-1:0]  alu_function,
  input  logic [IMM_W-1:0]    immediate,
  input  logic [TARGET_W-1:0] jump_target,
  output logic [INSTR_W-1:0]  word,
  output logic                legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    word[OPCODE_LSB +: OPCODE_W] = opcode;
    unique case (1'b1)
      (fmt == FMT_R): begin
        word[RS_LSB +: REG_W]       = rs;
        word[RT_LSB +: REG_W]       = rt;
        word[RD_LSB +: REG_W]       = rd;
        word[SHAMT_LSB +: SHAMT_W]  = shamt;
        word[FUNCT_LSB +: FUNCT_W]  = alu_function;
      end
      (fmt == FMT_I): begin
        word[RS_LSB +: REG_W]  = rs;
        word[RT_LSB +: REG_W]  = rt;
        word[IMM_LSB +: IMM_W] = immediate;
      end
      (fmt == FMT_J): begin
        word[TARGET_LSB +: TARGET_W] = jump_target;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_32.sv
// Encodes field bundles into 32-bit words, tags each with a word address
// and buffers them in a 2-entry FIFO between two valid/ready handshakes.
module instr_encoder_32
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          fmt,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [FUNCT_W-1:0]  alu_function,
  input  logic [IMM_W-1:0]    immediate,
  input  logic [TARGET_W-1:0] jump_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  instruction,
  output logic [ADDR_W-1:0]   address,
  output logic                err_illegal,
  output logic                addr_wrap
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  fifo_state_t         state, state_next;
  logic [INSTR_W-1:0]  head_word, tail_word, new_word;
  logic [ADDR_W-1:0]   head_addr, tail_addr;
  logic [ADDR_W-1:0]   cnt, tag;
  logic                legal, in_fire, push, pop, bad;

  instr_pack_32 u_pack (
    .fmt          (fmt),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shamt        (shamt),
    .alu_function (alu_function),
    .immediate    (immediate),
    .jump_target  (jump_target),
    .word         (new_word),
    .legal        (legal)
  );

  assign in_ready    = (state != FULL);
  assign out_valid   = (state != EMPTY);
  assign instruction = head_word;
  assign address     = head_addr;

  assign in_fire = in_valid && in_ready;
  assign push    = in_fire && legal;
  assign bad     = in_fire && !legal;
  assign pop     = out_valid && out_ready;
  // A restart retags the word arriving in the same cycle.
  assign tag     = restart ? BASE : cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL: if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_word   <= '0;
      head_addr   <= BASE;
      tail_word   <= '0;
      tail_addr   <= BASE;
      cnt         <= BASE;
      err_illegal <= 1'b0;
      addr_wrap   <= 1'b0;
    end else begin
      if (pop) begin
        if (state == FULL) begin
          head_word <= tail_word;
          head_addr <= tail_addr;
        end else if (push) begin
          head_word <= new_word;
          head_addr <= tag;
        end
      end else if (push) begin
        if (state == EMPTY) begin
          head_word <= new_word;
          head_addr <= tag;
        end else begin
          tail_word <= new_word;
          tail_addr <= tag;
        end
      end
      cnt         <= push ? tag + 1'b1 : tag;
      err_illegal <= bad || (err_illegal && !restart);
      addr_wrap   <= (push && (tag == '1)) || (addr_wrap && !restart);
    end
  end

endmodule

// File: tb/tb_instr_encoder_32.sv
// Directed bench for instr_encoder_32: vector table plus handshake,
// illegal, wrap, restart and reset sequences on three parameterisations.
module tb_instr_encoder_32;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode, alu_function;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] jump_target;

  logic        a_in_ready, a_out_valid, a_err, a_wrap;
  logic [31:0] a_instr;
  logic [7:0]  a_addr;
  logic        b_in_ready, b_out_valid, b_err, b_wrap;
  logic [31:0] b_instr;
  logic [1:0]  b_addr;
  logic        c_in_ready, c_out_valid, c_err, c_wrap;
  logic [31:0] c_instr;
  logic [7:0]  c_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_32 u_a (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(a_in_ready), .fmt(fmt),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .alu_function(alu_function), .immediate(immediate),
    .jump_target(jump_target), .out_valid(a_out_valid),
    .out_ready(out_ready), .instruction(a_instr), .address(a_addr),
    .err_illegal(a_err), .addr_wrap(a_wrap)
  );

  instr_encoder_32 #(.ADDR_W(2), .BASE_ADDR(0)) u_b (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(b_in_ready), .fmt(fmt),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .alu_function(alu_function), .immediate(immediate),
    .jump_target(jump_target), .out_valid(b_out_valid),
    .out_ready(out_ready), .instruction(b_instr), .address(b_addr),
    .err_illegal(b_err), .addr_wrap(b_wrap)
  );

  instr_encoder_32 #(.ADDR_W(8), .BASE_ADDR(4)) u_c (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(c_in_ready), .fmt(fmt),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .alu_function(alu_function), .immediate(immediate),
    .jump_target(jump_target), .out_valid(c_out_valid),
    .out_ready(out_ready), .instruction(c_instr), .address(c_addr),
    .err_illegal(c_err), .addr_wrap(c_wrap)
  );

  typedef struct {
    logic [1:0]  f;
    logic [5:0]  op;
    logic [4:0]  s, t, d, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    fmt = v.f; opcode = v.op; rs = v.s; rt = v.t; rd = v.d;
    shamt = v.sh; alu_function = v.fn; immediate = v.imm;
    jump_target = v.jt;
  endtask

  // add-style R word with rs=1, rt=2 and the given rd
  task automatic set_r(input logic [4:0] d);
    fmt = 2'd0; opcode = 6'd0; rs = 5'd1; rt = 5'd2; rd = d;
    shamt = 5'd0; alu_function = 6'h20; immediate = 16'hDEAD;
    jump_target = 26'h0;
  endtask

  function automatic logic [31:0] r_word(input logic [4:0] d);
    return 32'h00220020 | (32'(d) << 11);
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20,
                16'h0000, 26'h0, 32'h00221820};
    vecs[1] = '{2'd1, 6'h08, 5'd1, 5'd2, 5'd9, 5'd7, 6'h11,
                16'hFFFF, 26'h155, 32'h2022FFFF};
    vecs[2] = '{2'd2, 6'h02, 5'd5, 5'd6, 5'd7, 5'd8, 6'h3F,
                16'h1234, 26'h3FFFFFF, 32'h0BFFFFFF};
    vecs[3] = '{2'd0, 6'h3F, 5'd31, 5'd0, 5'd31, 5'd31, 6'h3F,
                16'h5555, 26'h2AAAAAA, 32'hFFE0FFFF};
    vecs[4] = '{2'd1, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F,
                16'h1234, 26'h3FFFFFF, 32'h8FA81234};
    vecs[5] = '{2'd2, 6'h03, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F,
                16'hFFFF, 26'h0000010, 32'h0C000010};

    reset = 1'b1; restart = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    set_r(5'd9);
    repeat (2) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_addr_base4", 32'(c_addr), 32'd4);
    chk("rst_flags", {30'd0, a_err, a_wrap}, 32'd0);

    // back-to-back stream, one word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(a_out_valid), 32'd1);
      chk($sformatf("vec%0d_instr", i), a_instr, vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), 32'(a_addr), 32'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_drain", 32'(a_out_valid), 32'd0);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    set_r(5'd1); in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_one", 32'(a_in_ready), 32'd1);
    set_r(5'd2);
    @(negedge clk);
    chk("bp_ready_full", 32'(a_in_ready), 32'd0);
    chk("bp_head0", a_instr, r_word(5'd1));
    set_r(5'd3);
    @(negedge clk);
    chk("bp_stable_instr", a_instr, r_word(5'd1));
    chk("bp_stable_addr", 32'(a_addr), 32'd0);
    chk("bp_still_full", 32'(a_in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out1", a_instr, r_word(5'd2));
    chk("bp_addr1", 32'(a_addr), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_out2", a_instr, r_word(5'd3));
    chk("bp_addr2", 32'(a_addr), 32'd2);
    @(negedge clk);
    chk("bp_empty", 32'(a_out_valid), 32'd0);

    // illegal format between two R words
    do_reset();
    set_r(5'd4); in_valid = 1'b1;
    @(negedge clk);
    chk("ill_w0", a_instr, r_word(5'd4));
    chk("ill_a0", 32'(a_addr), 32'd0);
    chk("ill_err_pre", 32'(a_err), 32'd0);
    fmt = 2'd3;
    @(negedge clk);
    chk("ill_none_out", 32'(a_out_valid), 32'd0);
    chk("ill_err", 32'(a_err), 32'd1);
    chk("ill_consumed", 32'(a_in_ready), 32'd1);
    set_r(5'd5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_w1", a_instr, r_word(5'd5));
    chk("ill_a1", 32'(a_addr), 32'd1);
    chk("ill_err_sticky", 32'(a_err), 32'd1);

    // wrap on the 2-bit counter
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_r(5'(i));
      @(negedge clk);
      chk($sformatf("wrap_addr%0d", i), 32'(b_addr), 32'(i % 4));
      chk($sformatf("wrap_flag%0d", i), 32'(b_wrap), (i >= 3) ? 32'd1 : 32'd0);
    end

    // restart with BASE_ADDR=4
    fmt = 2'd3;
    @(negedge clk);
    chk("rs_err_set", 32'(c_err), 32'd1);
    set_r(5'd7); restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_addr_base", 32'(c_addr), 32'd4);
    chk("rs_err_clr", 32'(c_err), 32'd0);
    chk("rs_wrap_clr", 32'(b_wrap), 32'd0);
    set_r(5'd8);
    @(negedge clk);
    chk("rs_addr_next", 32'(c_addr), 32'd5);
    chk("rs_instr_next", c_instr, r_word(5'd8));
    fmt = 2'd3; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    chk("rs_ill_priority", 32'(c_err), 32'd1);

    // reset while FULL
    out_ready = 1'b0;
    set_r(5'd1); in_valid = 1'b1;
    @(negedge clk);
    set_r(5'd2);
    @(negedge clk);
    chk("rf_full", 32'(a_in_ready), 32'd0);
    set_r(5'd3); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("rf_out_valid", 32'(a_out_valid), 32'd0);
    chk("rf_in_ready", 32'(a_in_ready), 32'd1);
    chk("rf_addr", 32'(c_addr), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
